vx_ahb_burst_master: RTL and testbench
======================================

VX_AHB_BURST_MASTER -- requirements
Module: vx_ahb_burst_master

Interface
REQ-001 Parameters:
- MEM_DATA_WIDTH, 512: cache-line width; a multiple of AHB_DATA_WIDTH, at most 8192.
- MEM_ADDR_WIDTH, 26: line address width.
- MEM_TAG_WIDTH, 8: request tag width.
- AHB_DATA_WIDTH, 32: bus width, 32 or 64.
- USE_BURST, 1: 1 = INCR burst, 0 = SINGLE transfer per beat.
- BEATS = MEM_DATA_WIDTH/AHB_DATA_WIDTH; STRB_W = AHB_DATA_WIDTH/8.

REQ-002 Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid/rw/byteen/addr/data/tag  in  1/1/MEM_DATA_WIDTH/8/MEM_ADDR_WIDTH/MEM_DATA_WIDTH/MEM_TAG_WIDTH  line request; rw=1 is write.
- mem_req_ready  out  1  request accept.
- mem_rsp_valid/data/tag  out  1/MEM_DATA_WIDTH/MEM_TAG_WIDTH  read response.
- mem_rsp_ready  in  1  response accept.
- HSEL, HWRITE  out  1 each.
- HTRANS  out  2.
- HBURST, HSIZE  out  3 each.
- HADDR  out  32.
- HWDATA  out  AHB_DATA_WIDTH.
- HWSTRB  out  STRB_W.
- HREADY, HRESP  in  1 each.
- HRDATA  in  AHB_DATA_WIDTH.
- busy  out  1  transaction in flight.
- err  out  1  sticky bus error.

Function
REQ-003 States: IDLE, XFER, RSP; busy=1 in any state other than IDLE.
REQ-004 mem_req_ready=1 only in IDLE. On valid&&ready, latch rw, addr, data, byteen and tag, then go to XFER; beat counter k=0.
REQ-005 Beat address: HADDR = ({addr, log2(MEM_DATA_WIDTH/8) zero bits} + k*STRB_W), truncated to 32 bits.
REQ-006 XFER address phase:
- First beat: HTRANS=NONSEQ (10) in the cycle after accept.
- Following beats: HTRANS=SEQ (11) if USE_BURST=1, otherwise NONSEQ.
- HBURST=INCR (001) if USE_BURST=1 and BEATS>1, otherwise SINGLE (000).
- HSIZE=log2(STRB_W); HWRITE=rw; HSEL=HTRANS[1].
REQ-007 Pipelining: the address phase of beat k+1 overlaps the data phase of beat k. Address/control outputs advance only on a cycle with HREADY=1; they are held otherwise.
REQ-008 Write data: HWDATA = data slice k and HWSTRB = byteen slice k, driven in the data phase of beat k (one cycle after its address is accepted), held while HREADY=0. HWSTRB=0 on reads.
REQ-009 Read data: HRDATA is captured into line slice k in the data-phase cycle with HREADY=1 and HRESP=0.
REQ-010 After the last beat's address is accepted, drive HTRANS=IDLE (00). After the last data phase completes:
- Read: go to RSP.
- Write: go to IDLE; no response is generated.
REQ-011 RSP: mem_rsp_valid=1 with the assembled line and the latched tag, held stable until mem_rsp_ready=1, then go to IDLE.
REQ-012 Zero-wait read latency: mem_rsp_valid is asserted BEATS+2 cycles after the accept edge.
REQ-013 Error handling:
- HRESP=1 with HREADY=0 in any data phase: in the next cycle drive HTRANS=IDLE, cancel all unissued beats, and set err=1 (cleared only by reset).
- Read: go to RSP after the second error cycle (HREADY=1); failed and cancelled slices are 0, completed slices are kept.
- Write: go to IDLE.
REQ-014 HTRANS=BUSY (01) is never issued. A line never crosses a 1 KB boundary (guaranteed by REQ-001 width bound and line alignment).

Reset
REQ-015 When reset=0, asynchronously:
- State=IDLE; busy, err, mem_rsp_valid, HSEL, HWRITE = 0; HTRANS=00.
- HADDR, HWDATA, HWSTRB, HBURST, HSIZE, mem_rsp_data, mem_rsp_tag = 0.
- mem_req_ready=0.
REQ-016 A reset asserted mid-burst abandons the transaction; no response is produced. mem_req_ready=1 from the first clk edge after reset deasserts.

Verification (MEM_DATA_WIDTH=128, AHB_DATA_WIDTH=32, USE_BURST=1)
REQ-017 Reset check: pulse reset low for 3 cycles -> outputs at REQ-015 values; mem_req_ready=1 on the first edge after release.
REQ-018 Zero-wait read: read line 0x10, tag 0x5A, HRDATA A0..A3 -> HADDR 0x100/0x104/0x108/0x10C; HTRANS 10,11,11,11 then 00; HBURST=001; response {A3,A2,A1,A0}, tag 0x5A, at accept+6.
REQ-019 Write with strobes: write line 0x2, byteen 0x00F0 -> HWRITE=1; HWSTRB per beat 0,F,0,0; each HWDATA word lags its HADDR by one cycle; mem_rsp_valid stays 0; busy drops after the beat-3 data phase.
REQ-020 Wait states: hold HREADY=0 for 2 cycles during the beat-1 data phase -> beat-2 HADDR/HTRANS and beat-1 HWDATA stay stable; total latency grows by exactly 2 cycles.
REQ-021 Read error: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on beat 2 -> HTRANS=00 in the second cycle; beat 3 never issued; response {0,0,A1,A0}; err=1 persists.
REQ-022 Back-pressure and mid-burst reset: mem_rsp_ready=0 for 3 cycles -> response held stable, mem_req_ready=0, HTRANS=00; separately, reset during beat 1 -> HTRANS=00 immediately and no response.

Source files
------------

// File: rtl/vx_ahb_burst_master_if.sv
// Purpose: bundles the cache-line request/response handshake, the AHB-Lite master bus
//          and the busy/err status of vx_ahb_burst_master into one port.
// Latency: none, wires only.
// Backpressure: mem_req_ready/mem_rsp_ready on the line side, HREADY on the AHB side.
// Ports: master = burst master view; slave = memory client + AHB slave view (testbench side).
interface vx_ahb_burst_master_if #(
    parameter int MEM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter int MEM_TAG_WIDTH  = 8,
    parameter int AHB_DATA_WIDTH = 32
);
    localparam int STRB_W = AHB_DATA_WIDTH / 8;

    logic                        mem_req_valid;
    logic                        mem_req_rw;
    logic [MEM_DATA_WIDTH/8-1:0] mem_req_byteen;
    logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr;
    logic [MEM_DATA_WIDTH-1:0]   mem_req_data;
    logic [MEM_TAG_WIDTH-1:0]    mem_req_tag;
    logic                        mem_req_ready;

    logic                        mem_rsp_valid;
    logic [MEM_DATA_WIDTH-1:0]   mem_rsp_data;
    logic [MEM_TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                        mem_rsp_ready;

    logic                        HSEL;
    logic                        HWRITE;
    logic [1:0]                  HTRANS;
    logic [2:0]                  HBURST;
    logic [2:0]                  HSIZE;
    logic [31:0]                 HADDR;
    logic [AHB_DATA_WIDTH-1:0]   HWDATA;
    logic [STRB_W-1:0]           HWSTRB;
    logic                        HREADY;
    logic                        HRESP;
    logic [AHB_DATA_WIDTH-1:0]   HRDATA;

    logic                        busy;
    logic                        err;

    modport master (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready,
        output HSEL, HWRITE, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA,
        output busy, err
    );

    modport slave (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready,
        input  HSEL, HWRITE, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA,
        input  busy, err
    );
endinterface

// File: rtl/vx_ahb_burst_master.sv
// Purpose: converts one cache-line read/write into BEATS pipelined AHB-Lite transfers.
// Latency: first address phase 1 cycle after accept; zero-wait read response BEATS+2 cycles after accept.
// Backpressure: one line in flight (ready only in IDLE); HREADY stalls the bus pipeline; response held until mem_rsp_ready.
// Ports: clk, reset (async active-low), bus (vx_ahb_burst_master_if.master).
module vx_ahb_burst_master #(
    parameter int MEM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter int MEM_TAG_WIDTH  = 8,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int USE_BURST      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    vx_ahb_burst_master_if.master  bus
);
    localparam int BEATS  = MEM_DATA_WIDTH / AHB_DATA_WIDTH;
    localparam int STRB_W = AHB_DATA_WIDTH / 8;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS   = $clog2(MEM_DATA_WIDTH / 8);
    localparam int EXT_W  = (MEM_ADDR_WIDTH + OFFS > 32) ? MEM_ADDR_WIDTH + OFFS : 32;
    localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // Byte address of beat k of a line; the line is aligned so this never crosses 1 KB.
    function automatic logic [31:0] beat_addr(input logic [MEM_ADDR_WIDTH-1:0] la, input logic [KW-1:0] k);
        logic [EXT_W-1:0] base;
        logic [EXT_W-1:0] off;
        logic [EXT_W-1:0] sum;
        base = EXT_W'({la, {OFFS{1'b0}}});
        off  = EXT_W'(k) << $clog2(STRB_W);
        sum  = base + off;
        return sum[31:0];
    endfunction

    logic [1:0]                  state_q, state_d;
    logic                        ready_q, ready_d;
    logic                        rw_q, rw_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0]   data_q, data_d;
    logic [MEM_DATA_WIDTH/8-1:0] byteen_q, byteen_d;
    logic [MEM_TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [MEM_DATA_WIDTH-1:0]   line_q, line_d;
    logic [KW-1:0]               a_k_q, a_k_d;       // beat in address phase
    logic [KW-1:0]               d_k_q, d_k_d;       // beat in data phase
    logic                        addr_act_q, addr_act_d;
    logic                        dp_q, dp_d;
    logic                        err_q, err_d;
    logic                        rsp_vld_q, rsp_vld_d;
    logic [1:0]                  htrans_q, htrans_d;
    logic [31:0]                 haddr_q, haddr_d;
    logic [2:0]                  hburst_q, hburst_d;
    logic [2:0]                  hsize_q, hsize_d;
    logic [AHB_DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
    logic [STRB_W-1:0]           hwstrb_q, hwstrb_d;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byteen_d   = byteen_q;
        tag_d      = tag_q;
        line_d     = line_q;
        a_k_d      = a_k_q;
        d_k_d      = d_k_q;
        addr_act_d = addr_act_q;
        dp_d       = dp_q;
        err_d      = err_q;
        rsp_vld_d  = rsp_vld_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hburst_d   = hburst_q;
        hsize_d    = hsize_q;
        hwdata_d   = hwdata_q;
        hwstrb_d   = hwstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_req_valid && ready_q) begin
                    state_d    = ST_XFER;
                    rw_d       = bus.mem_req_rw;
                    addr_d     = bus.mem_req_addr;
                    data_d     = bus.mem_req_data;
                    byteen_d   = bus.mem_req_byteen;
                    tag_d      = bus.mem_req_tag;
                    line_d     = '0;   // cancelled/failed slices must read back as zero
                    a_k_d      = '0;
                    addr_act_d = 1'b1;
                    dp_d       = 1'b0;
                    htrans_d   = TR_NONSEQ;
                    haddr_d    = beat_addr(bus.mem_req_addr, '0);
                    hburst_d   = (USE_BURST != 0 && BEATS > 1) ? 3'b001 : 3'b000;
                    hsize_d    = 3'($clog2(STRB_W));
                end
            end
            ST_XFER: begin
                if (dp_q && bus.HRESP) begin
                    err_d = 1'b1;
                end
                if (dp_q && bus.HRESP && !bus.HREADY) begin
                    // First error cycle: drop the pending address phase and everything after it.
                    htrans_d   = TR_IDLE;
                    addr_act_d = 1'b0;
                end else if (bus.HREADY) begin
                    if (dp_q && !bus.HRESP && !rw_q) begin
                        line_d[d_k_q*AHB_DATA_WIDTH +: AHB_DATA_WIDTH] = bus.HRDATA;
                    end
                    if (addr_act_q) begin
                        // Address of a_k accepted: its data phase starts now.
                        dp_d     = 1'b1;
                        d_k_d    = a_k_q;
                        hwdata_d = data_q[a_k_q*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
                        hwstrb_d = rw_q ? byteen_q[a_k_q*STRB_W +: STRB_W] : '0;
                        if (a_k_q == LAST_K) begin
                            addr_act_d = 1'b0;
                            htrans_d   = TR_IDLE;
                        end else begin
                            a_k_d    = a_k_q + KW'(1);
                            htrans_d = (USE_BURST != 0) ? TR_SEQ : TR_NONSEQ;
                            haddr_d  = beat_addr(addr_q, a_k_q + KW'(1));
                        end
                    end else begin
                        dp_d = 1'b0;
                        if (dp_q) begin
                            state_d = rw_q ? ST_IDLE : ST_RSP;
                        end
                    end
                end
            end
            ST_RSP: begin
                if (rsp_vld_q && bus.mem_rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    rsp_vld_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so ready stays low during reset and rises on the first edge after it.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            byteen_q   <= '0;
            tag_q      <= '0;
            line_q     <= '0;
            a_k_q      <= '0;
            d_k_q      <= '0;
            addr_act_q <= 1'b0;
            dp_q       <= 1'b0;
            err_q      <= 1'b0;
            rsp_vld_q  <= 1'b0;
            htrans_q   <= TR_IDLE;
            haddr_q    <= '0;
            hburst_q   <= '0;
            hsize_q    <= '0;
            hwdata_q   <= '0;
            hwstrb_q   <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byteen_q   <= byteen_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            a_k_q      <= a_k_d;
            d_k_q      <= d_k_d;
            addr_act_q <= addr_act_d;
            dp_q       <= dp_d;
            err_q      <= err_d;
            rsp_vld_q  <= rsp_vld_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hburst_q   <= hburst_d;
            hsize_q    <= hsize_d;
            hwdata_q   <= hwdata_d;
            hwstrb_q   <= hwstrb_d;
        end
    end

    assign bus.mem_req_ready = ready_q;
    assign bus.mem_rsp_valid = rsp_vld_q;
    assign bus.mem_rsp_data  = line_q;
    assign bus.mem_rsp_tag   = tag_q;
    assign bus.HSEL          = htrans_q[1];
    assign bus.HWRITE        = rw_q;
    assign bus.HTRANS        = htrans_q;
    assign bus.HBURST        = hburst_q;
    assign bus.HSIZE         = hsize_q;
    assign bus.HADDR         = haddr_q;
    assign bus.HWDATA        = hwdata_q;
    assign bus.HWSTRB        = hwstrb_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.err           = err_q;
endmodule

// File: tb/tb_vx_ahb_burst_master.sv
// Purpose: directed self-checking bench for vx_ahb_burst_master (128-bit line, 32-bit AHB, INCR bursts).
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: HREADY wait states, HRESP errors and mem_rsp_ready stalls driven from the stimulus.
module tb_vx_ahb_burst_master;
    localparam int MDW = 128;
    localparam int MAW = 26;
    localparam int MTW = 8;
    localparam int ADW = 32;
    localparam int UB  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_ahb_burst_master_if #(.MEM_DATA_WIDTH(MDW), .MEM_ADDR_WIDTH(MAW),
                             .MEM_TAG_WIDTH(MTW), .AHB_DATA_WIDTH(ADW)) bus ();

    vx_ahb_burst_master #(.MEM_DATA_WIDTH(MDW), .MEM_ADDR_WIDTH(MAW), .MEM_TAG_WIDTH(MTW),
                          .AHB_DATA_WIDTH(ADW), .USE_BURST(UB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [31:0]  rw_word [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    logic [31:0]  wr_word [4] = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
    logic [127:0] wline = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    logic [15:0]  be    = 16'h00F0;
    logic [127:0] held;

    task automatic req(input logic rw, input logic [25:0] a, input logic [7:0] t, input logic [15:0] b);
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_rw     = rw;
        bus.mem_req_addr   = a;
        bus.mem_req_tag    = t;
        bus.mem_req_byteen = b;
        bus.mem_req_data   = wline;
    endtask

    initial begin
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_rw     = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_tag    = '0;
        bus.mem_req_byteen = '0;
        bus.mem_req_data   = '0;
        bus.mem_rsp_ready  = 1'b1;
        bus.HREADY         = 1'b1;
        bus.HRESP          = 1'b0;
        bus.HRDATA         = '0;

        // ---- reset held low for 3 cycles ----
        repeat (3) tick();
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_ctrl", {bus.HSEL, bus.HWRITE, bus.busy, bus.err, bus.mem_rsp_valid, bus.mem_req_ready}, 6'b0);
        check("rst_bus", {bus.HADDR, bus.HWDATA, bus.HWSTRB, bus.HBURST, bus.HSIZE}, 78'b0);
        check("rst_rsp", {bus.mem_rsp_data[63:0], bus.mem_rsp_tag}, 72'b0);
        reset = 1'b1;
        #1 check("rel_ready_pre", bus.mem_req_ready, 1'b0);
        tick();
        check("rel_ready", bus.mem_req_ready, 1'b1);

        // ---- zero-wait read, line 0x10, tag 0x5A ----
        req(1'b0, 26'h10, 8'h5A, 16'hFFFF);
        tick();
        bus.mem_req_valid = 1'b0;
        check("rd_htrans0", bus.HTRANS, 2'b10);
        check("rd_haddr0", bus.HADDR, 32'h100);
        check("rd_ctrl", {bus.HBURST, bus.HSIZE, bus.HSEL, bus.HWRITE, bus.busy, bus.mem_req_ready}, 10'b001_010_1_0_1_0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.HRDATA = rw_word[k-1];
            if (k < 4) begin
                check($sformatf("rd_haddr%0d", k), bus.HADDR, 32'h100 + 4*k);
                check($sformatf("rd_htrans%0d", k), bus.HTRANS, 2'b11);
            end else begin
                check("rd_htrans_end", bus.HTRANS, 2'b00);
            end
        end
        tick();
        check("rd_vld_early", bus.mem_rsp_valid, 1'b0);
        tick();
        check("rd_vld", bus.mem_rsp_valid, 1'b1);
        check("rd_data", bus.mem_rsp_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        check("rd_tag", bus.mem_rsp_tag, 8'h5A);
        tick();
        check("rd_done", {bus.mem_rsp_valid, bus.busy, bus.mem_req_ready}, 3'b001);

        // ---- write line 0x2, byteen 0x00F0 ----
        req(1'b1, 26'h2, 8'h11, be);
        tick();
        bus.mem_req_valid = 1'b0;
        check("wr_first", {bus.HWRITE, bus.HTRANS, bus.HADDR}, {1'b1, 2'b10, 32'h20});
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("wr_hwdata%0d", k-1), bus.HWDATA, wr_word[k-1]);
            check($sformatf("wr_hwstrb%0d", k-1), bus.HWSTRB, be[(k-1)*4 +: 4]);
            if (k < 4) check($sformatf("wr_haddr%0d", k), bus.HADDR, 32'h20 + 4*k);
        end
        check("wr_busy_last", bus.busy, 1'b1);
        tick();
        check("wr_end", {bus.busy, bus.mem_rsp_valid, bus.HTRANS}, 4'b0000);

        // ---- write with 2 wait states in beat-1 data phase ----
        req(1'b1, 26'h2, 8'h22, 16'hFFFF);
        tick();
        bus.mem_req_valid = 1'b0;
        tick();
        check("ws_hwdata0", bus.HWDATA, wr_word[0]);
        tick();
        bus.HREADY = 1'b0;
        check("ws_beat1", {bus.HADDR, bus.HTRANS, bus.HWDATA}, {32'h28, 2'b11, wr_word[1]});
        for (int w = 0; w < 2; w++) begin
            tick();
            check($sformatf("ws_hold%0d", w), {bus.HADDR, bus.HTRANS, bus.HWDATA}, {32'h28, 2'b11, wr_word[1]});
        end
        bus.HREADY = 1'b1;
        tick();
        check("ws_beat2", {bus.HADDR, bus.HWDATA}, {32'h2C, wr_word[2]});
        tick();
        check("ws_beat3", {bus.HTRANS, bus.HWDATA, bus.busy}, {2'b00, wr_word[3], 1'b1});
        tick();
        check("ws_end", bus.busy, 1'b0);

        // ---- read with error on beat 2, then response back-pressure ----
        req(1'b0, 26'h10, 8'h77, 16'hFFFF);
        tick();
        bus.mem_req_valid = 1'b0;
        tick(); bus.HRDATA = rw_word[0];
        tick(); bus.HRDATA = rw_word[1];
        tick();
        check("er_beat3_addr", {bus.HADDR, bus.HTRANS}, {32'h10C, 2'b11});
        bus.HRDATA = rw_word[2];
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        check("er_htrans_idle", bus.HTRANS, 2'b00);
        check("er_err", bus.err, 1'b1);
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 1'b0;
        bus.mem_rsp_ready = 1'b0;
        check("er_no_beat3", {bus.HTRANS, bus.mem_rsp_valid}, 3'b000);
        tick();
        check("er_data", bus.mem_rsp_data, 128'h0_A1A1A1A1_A0A0A0A0);
        held = bus.mem_rsp_data;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("bp_hold%0d", s), {bus.mem_rsp_valid, bus.mem_req_ready, bus.HTRANS, bus.mem_rsp_tag},
                  {1'b1, 1'b0, 2'b00, 8'h77});
            check($sformatf("bp_data%0d", s), bus.mem_rsp_data, held);
        end
        bus.mem_rsp_ready = 1'b1;
        tick();
        check("bp_done", {bus.mem_rsp_valid, bus.mem_req_ready, bus.err}, 3'b011);

        // ---- reset during beat 1 ----
        req(1'b0, 26'h10, 8'h99, 16'hFFFF);
        tick();
        bus.mem_req_valid = 1'b0;
        tick();
        check("mr_beat1", {bus.HADDR, bus.HTRANS}, {32'h104, 2'b11});
        reset = 1'b0;
        #1 check("mr_async", {bus.HTRANS, bus.busy, bus.err, bus.mem_req_ready}, 5'b0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("mr_norsp%0d", c), {bus.mem_rsp_valid, bus.HTRANS, bus.busy, bus.mem_req_ready}, 5'b00001);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
